// File: rtl/swap_eval_pkg.sv
// Shared types and encodings for the edge-swap cost evaluator.
package swap_eval_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam int DIST_MANHATTAN = 0;
  localparam int DIST_SQEUCLID  = 1;
endpackage

// File: rtl/swap_eval_dist.sv
// Combinational point-to-point distance; result width covers the worst case of either metric.
module dist_unit
  import swap_eval_pkg::*;
#(
  parameter int CW    = 8,
  parameter int DMODE = DIST_MANHATTAN
) (
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic [2*CW:0] d
);
  logic [CW-1:0] dx, dy;

  assign dx = (x0 >= x1) ? x0 - x1 : x1 - x0;
  assign dy = (y0 >= y1) ? y0 - y1 : y1 - y0;

  generate
    if (DMODE == DIST_SQEUCLID) begin : g_sq
      logic [2*CW:0] wx, wy;
      assign wx = {{(CW+1){1'b0}}, dx};
      assign wy = {{(CW+1){1'b0}}, dy};
      // each square fits in 2*CW bits, so the sum fits in 2*CW+1
      assign d  = wx * wx + wy * wy;
    end else begin : g_man
      assign d = {{(CW+1){1'b0}}, dx} + {{(CW+1){1'b0}}, dy};
    end
  endgenerate
endmodule

// File: rtl/swap_eval.sv
// Compares total length of two candidate edge sets, one edge per cycle through a shared distance unit.
module swap_eval
  import swap_eval_pkg::*;
#(
  parameter int CW    = 8,
  parameter int NP    = 6,
  parameter int NE    = 4,
  parameter int DW    = 32,
  parameter int DMODE = DIST_MANHATTAN,
  localparam int IW   = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NP*CW-1:0]   px,
  input  logic [NP*CW-1:0]   py,
  input  logic [NE*IW-1:0]   ea_u,
  input  logic [NE*IW-1:0]   ea_v,
  input  logic [NE*IW-1:0]   eb_u,
  input  logic [NE*IW-1:0]   eb_v,
  output logic               busy,
  output logic               done,
  output logic               res,
  output logic               eq,
  output logic               err,
  output logic [DW:0]        difference
);
  localparam int DISTW = 2*CW + 1;
  localparam int CNTW  = (2*NE > 1) ? $clog2(2*NE) : 1;

  if (DW < 2*CW + 2 + $clog2(NE)) begin : g_dw_chk
    $error("swap_eval: DW too small for CW/NE");
  end
  if (DMODE != DIST_MANHATTAN && DMODE != DIST_SQEUCLID) begin : g_dm_chk
    $error("swap_eval: unsupported DMODE");
  end

  state_t state_q, state_d;

  logic [NP-1:0][CW-1:0]   px_r, py_r;
  // A edges in slots 0..NE-1, B edges in NE..2NE-1: issue order is just the slot index
  logic [2*NE-1:0][IW-1:0] eu_r, ev_r;
  logic [CNTW-1:0]         cnt;
  logic [DISTW-1:0]        dist_c, dist_r;
  logic                    dvld, dsel;
  logic [DW-1:0]           sum_a, sum_b;
  logic                    idx_bad;
  logic [CW-1:0]           ux, uy, vx, vy;
  logic [DW:0]             diff_c;

  // out-of-range indices read as the origin; the result is discarded via err anyway
  always_comb begin
    ux = '0; uy = '0; vx = '0; vy = '0;
    if (32'(eu_r[cnt]) < NP) begin
      ux = px_r[eu_r[cnt]];
      uy = py_r[eu_r[cnt]];
    end
    if (32'(ev_r[cnt]) < NP) begin
      vx = px_r[ev_r[cnt]];
      vy = py_r[ev_r[cnt]];
    end
  end

  always_comb begin
    idx_bad = 1'b0;
    for (int k = 0; k < 2*NE; k++)
      if (32'(eu_r[k]) >= NP || 32'(ev_r[k]) >= NP) idx_bad = 1'b1;
  end

  dist_unit #(.CW(CW), .DMODE(DMODE)) u_dist (
    .x0(ux), .y0(uy), .x1(vx), .y1(vy), .d(dist_c)
  );

  assign diff_c = {1'b0, sum_a} - {1'b0, sum_b};
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (cnt == CNTW'(2*NE-1)) state_d = DRAIN;
      DRAIN:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_r <= '0; py_r <= '0; eu_r <= '0; ev_r <= '0;
      cnt <= '0; dist_r <= '0; dvld <= 1'b0; dsel <= 1'b0;
      sum_a <= '0; sum_b <= '0;
      done <= 1'b0; res <= 1'b0; eq <= 1'b0; err <= 1'b0; difference <= '0;
    end else begin
      done   <= 1'b0;
      dvld   <= (state_q == ISSUE);
      dsel   <= (cnt >= CNTW'(NE));
      dist_r <= dist_c;
      if (dvld) begin
        if (dsel) sum_b <= sum_b + DW'(dist_r);
        else      sum_a <= sum_a + DW'(dist_r);
      end
      case (state_q)
        IDLE: if (start) begin
          px_r  <= px;
          py_r  <= py;
          eu_r  <= {eb_u, ea_u};
          ev_r  <= {eb_v, ea_v};
          cnt   <= '0;
          sum_a <= '0;
          sum_b <= '0;
        end
        ISSUE: cnt <= cnt + 1'b1;
        FIN: begin
          done <= 1'b1;
          err  <= idx_bad;
          if (idx_bad) begin
            res <= 1'b0; eq <= 1'b0; difference <= '0;
          end else begin
            res <= (sum_a > sum_b);
            eq  <= (sum_a == sum_b);
            difference <= diff_c;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_swap_eval.sv
// Self-checking bench: two NE=2/NP=4 instances (both metrics) and one default-size instance.
module tb_swap_eval;
  logic clk, rst;

  logic        s_start;
  logic [31:0] s_px, s_py;
  logic [3:0]  s_eau, s_eav, s_ebu, s_ebv;
  logic        m_busy, m_done, m_res, m_eq, m_err;
  logic [32:0] m_diff;
  logic        q_busy, q_done, q_res, q_eq, q_err;
  logic [32:0] q_diff;

  logic        b_start;
  logic [47:0] b_px, b_py;
  logic [11:0] b_eau, b_eav, b_ebu, b_ebv;
  logic        b_busy, b_done, b_res, b_eq, b_err;
  logic [32:0] b_diff;

  int errors = 0, checks = 0;
  int x[6], y[6], au[4], av[4], bu[4], bv[4];

  swap_eval #(.CW(8), .NP(4), .NE(2), .DW(32), .DMODE(0)) u_m (
    .clk(clk), .rst(rst), .start(s_start), .px(s_px), .py(s_py),
    .ea_u(s_eau), .ea_v(s_eav), .eb_u(s_ebu), .eb_v(s_ebv),
    .busy(m_busy), .done(m_done), .res(m_res), .eq(m_eq), .err(m_err), .difference(m_diff));

  swap_eval #(.CW(8), .NP(4), .NE(2), .DW(32), .DMODE(1)) u_q (
    .clk(clk), .rst(rst), .start(s_start), .px(s_px), .py(s_py),
    .ea_u(s_eau), .ea_v(s_eav), .eb_u(s_ebu), .eb_v(s_ebv),
    .busy(q_busy), .done(q_done), .res(q_res), .eq(q_eq), .err(q_err), .difference(q_diff));

  swap_eval u_b (
    .clk(clk), .rst(rst), .start(b_start), .px(b_px), .py(b_py),
    .ea_u(b_eau), .ea_v(b_eav), .eb_u(b_ebu), .eb_v(b_ebv),
    .busy(b_busy), .done(b_done), .res(b_res), .eq(b_eq), .err(b_err), .difference(b_diff));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic longint edist(int dm, int i, int j);
    longint dx, dy;
    dx = x[i] - x[j];
    dy = y[i] - y[j];
    if (dm == 1) return dx*dx + dy*dy;
    return (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
  endfunction

  function automatic longint model_diff(int dm, int ne);
    longint ca = 0, cb = 0;
    for (int k = 0; k < ne; k++) begin
      ca += edist(dm, au[k], av[k]);
      cb += edist(dm, bu[k], bv[k]);
    end
    return ca - cb;
  endfunction

  function automatic bit model_err(int np, int ne);
    for (int k = 0; k < ne; k++)
      if (au[k] >= np || av[k] >= np || bu[k] >= np || bv[k] >= np) return 1;
    return 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply();
    for (int i = 0; i < 6; i++) begin
      b_px[i*8 +: 8] = x[i][7:0];
      b_py[i*8 +: 8] = y[i][7:0];
    end
    for (int i = 0; i < 4; i++) begin
      s_px[i*8 +: 8] = x[i][7:0];
      s_py[i*8 +: 8] = y[i][7:0];
      b_eau[i*3 +: 3] = au[i][2:0]; b_eav[i*3 +: 3] = av[i][2:0];
      b_ebu[i*3 +: 3] = bu[i][2:0]; b_ebv[i*3 +: 3] = bv[i][2:0];
    end
    for (int k = 0; k < 2; k++) begin
      s_eau[k*2 +: 2] = au[k][1:0]; s_eav[k*2 +: 2] = av[k][1:0];
      s_ebu[k*2 +: 2] = bu[k][1:0]; s_ebv[k*2 +: 2] = bv[k][1:0];
    end
  endtask

  task automatic randomize_inputs(int np, bit allow_bad);
    for (int i = 0; i < 6; i++) begin
      x[i] = $urandom_range(255);
      y[i] = $urandom_range(255);
    end
    for (int k = 0; k < 4; k++) begin
      au[k] = $urandom_range(np-1); av[k] = $urandom_range(np-1);
      bu[k] = $urandom_range(np-1); bv[k] = $urandom_range(np-1);
    end
    if (allow_bad && $urandom_range(3) == 0) begin
      case ($urandom_range(3))
        0: au[$urandom_range(3)] = $urandom_range(7, 6);
        1: av[$urandom_range(3)] = $urandom_range(7, 6);
        2: bu[$urandom_range(3)] = $urandom_range(7, 6);
        default: bv[$urandom_range(3)] = $urandom_range(7, 6);
      endcase
    end
    apply();
  endtask

  // Pulses start for the chosen instance set and returns cycles to done (-1 on timeout).
  task automatic launch(input int which, input bit scramble, input int pulse_at, output int lat);
    @(negedge clk);
    if (which == 0) s_start = 1; else b_start = 1;
    @(posedge clk); #1;
    s_start = 0; b_start = 0;
    if (scramble) randomize_inputs(6, 1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (which == 0) s_start = (c == pulse_at); else b_start = (c == pulse_at);
      if ((which == 0 ? m_done : b_done) === 1'b1) begin
        lat = c;
        break;
      end
    end
    s_start = 0; b_start = 0;
  endtask

  task automatic set_square();
    x = '{0, 10, 10, 0, 0, 0};
    y = '{0, 0, 10, 10, 0, 0};
    au = '{0, 1, 0, 0}; av = '{2, 3, 0, 0};
    bu = '{0, 2, 0, 0}; bv = '{1, 3, 0, 0};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; s_start = 0; b_start = 0;
    set_square(); apply();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({m_busy, m_done, m_res, m_eq, m_err, m_diff} !== '0) begin
      errors++; $display("FAIL reset_m: got %b want 0", {m_busy, m_done, m_res, m_eq, m_err, m_diff});
    end
    checks++;
    if ({q_busy, q_done, q_res, q_eq, q_err, q_diff} !== '0) begin
      errors++; $display("FAIL reset_q: got %b want 0", {q_busy, q_done, q_res, q_eq, q_err, q_diff});
    end
    checks++;
    if ({b_busy, b_done, b_res, b_eq, b_err, b_diff} !== '0) begin
      errors++; $display("FAIL reset_b: got %b want 0", {b_busy, b_done, b_res, b_eq, b_err, b_diff});
    end
    @(negedge clk) rst = 1;
  endtask

  task automatic test_square();
    int lat;
    set_square(); apply();
    launch(0, 0, 0, lat);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL square_latency: got %0d want 6", lat); end
    checks++;
    if ({m_res, m_eq, m_err, m_diff} !== {3'b100, 33'd20}) begin
      errors++; $display("FAIL square_manhattan: res=%b eq=%b err=%b diff=%0d want 1 0 0 20", m_res, m_eq, m_err, $signed(m_diff));
    end
    checks++;
    if ({q_done, q_res, q_eq, q_diff} !== {3'b110, 33'd200}) begin
      errors++; $display("FAIL square_sqeuclid: done=%b res=%b eq=%b diff=%0d want 1 1 0 200", q_done, q_res, q_eq, $signed(q_diff));
    end
    @(posedge clk); #1;
    checks++;
    if ({m_done, m_busy, m_res, m_diff} !== {3'b001, 33'd20}) begin
      errors++; $display("FAIL done_pulse_hold: done=%b busy=%b res=%b diff=%0d want 0 0 1 20", m_done, m_busy, m_res, $signed(m_diff));
    end
  endtask

  task automatic test_equal_swap();
    int lat;
    logic [32:0] em, eq2;
    set_square();
    bu = '{0, 1, 0, 0}; bv = '{2, 3, 0, 0};
    apply();
    launch(0, 0, 0, lat);
    checks++;
    if ({lat == 6, m_res, m_eq, m_diff, q_res, q_eq, q_diff} !== {3'b101, 33'd0, 2'b01, 33'd0}) begin
      errors++; $display("FAIL equal_sets: lat=%0d res=%b eq=%b diff=%0d qres=%b qeq=%b qdiff=%0d want 6 0 1 0 0 1 0",
                         lat, m_res, m_eq, $signed(m_diff), q_res, q_eq, $signed(q_diff));
    end
    set_square();
    au = '{0, 2, 0, 0}; av = '{1, 3, 0, 0};
    bu = '{0, 1, 0, 0}; bv = '{2, 3, 0, 0};
    apply();
    @(posedge clk);
    launch(0, 0, 0, lat);
    em = -33'sd20; eq2 = -33'sd200;
    checks++;
    if ({m_res, m_eq, m_diff} !== {2'b00, em}) begin
      errors++; $display("FAIL swapped_manhattan: res=%b eq=%b diff=%0d want 0 0 -20", m_res, m_eq, $signed(m_diff));
    end
    checks++;
    if ({q_res, q_diff} !== {1'b0, eq2}) begin
      errors++; $display("FAIL swapped_sqeuclid: res=%b diff=%0d want 0 -200", q_res, $signed(q_diff));
    end
  endtask

  task automatic test_max();
    int lat;
    x = '{255, 0, 7, 0, 0, 0};
    y = '{255, 0, 9, 0, 0, 0};
    au = '{0, 1, 0, 1}; av = '{1, 0, 1, 0};
    bu = '{2, 2, 3, 4}; bv = '{2, 2, 3, 4};
    apply();
    launch(1, 0, 0, lat);
    checks++;
    if ({lat == 10, b_res, b_eq, b_err, b_diff} !== {4'b1100, 33'd2040}) begin
      errors++; $display("FAIL max_span: lat=%0d res=%b eq=%b err=%b diff=%0d want 10 1 0 0 2040",
                         lat, b_res, b_eq, b_err, $signed(b_diff));
    end
  endtask

  task automatic test_err();
    int lat;
    randomize_inputs(6, 0);
    au[0] = 7;
    apply();
    launch(1, 0, 0, lat);
    checks++;
    if ({lat == 10, b_err, b_res, b_eq, b_diff} !== {4'b1100, 33'd0}) begin
      errors++; $display("FAIL index_err: lat=%0d err=%b res=%b eq=%b diff=%0d want 10 1 0 0 0",
                         lat, b_err, b_res, b_eq, $signed(b_diff));
    end
    randomize_inputs(6, 0);
    bv[3] = 6;
    apply();
    @(posedge clk);
    launch(1, 0, 0, lat);
    checks++;
    if ({b_err, b_res, b_diff} !== {2'b10, 33'd0}) begin
      errors++; $display("FAIL index_err_np: err=%b res=%b diff=%0d want 1 0 0", b_err, b_res, $signed(b_diff));
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    longint e;
    randomize_inputs(6, 0);
    e = model_diff(0, 4);
    launch(1, 1, 2, lat);
    checks++;
    if (lat !== 10 || b_diff !== 33'(e)) begin
      errors++; $display("FAIL start_while_busy: lat=%0d diff=%0d want 10 %0d", lat, $signed(b_diff), e);
    end
    // a start raised in the FIN cycle must not spawn another run
    randomize_inputs(6, 0);
    e = model_diff(0, 4);
    @(posedge clk);
    launch(1, 0, 9, lat);
    extra = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (b_done === 1'b1) extra++;
    end
    checks++;
    if (lat !== 10 || extra !== 0 || b_busy !== 1'b0 || b_diff !== 33'(e)) begin
      errors++; $display("FAIL start_in_fin: lat=%0d extra_done=%0d busy=%b diff=%0d want 10 0 0 %0d",
                         lat, extra, b_busy, $signed(b_diff), e);
    end
  endtask

  task automatic test_abort();
    int lat, seen;
    longint e;
    randomize_inputs(6, 0);
    @(negedge clk) b_start = 1;
    @(posedge clk); #1 b_start = 0;
    @(posedge clk); #1 b_start = 1;
    @(posedge clk); #1 b_start = 0;
    @(posedge clk); #1 rst = 0;
    #1;
    checks++;
    if ({b_busy, b_done, b_res, b_eq, b_err, b_diff} !== '0) begin
      errors++; $display("FAIL async_reset: got %b want 0", {b_busy, b_done, b_res, b_eq, b_err, b_diff});
    end
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 2) rst = 1;
      if (b_done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done: done_pulses=%0d busy=%b want 0 0", seen, b_busy);
    end
    randomize_inputs(6, 0);
    e = model_diff(0, 4);
    launch(1, 0, 0, lat);
    checks++;
    if (lat !== 10 || b_diff !== 33'(e) || b_res !== (e > 0)) begin
      errors++; $display("FAIL after_abort: lat=%0d diff=%0d res=%b want 10 %0d %b", lat, $signed(b_diff), b_res, e, e > 0);
    end
  endtask

  task automatic test_random();
    int lat;
    longint e, es;
    bit be;
    for (int it = 0; it < 24; it++) begin
      randomize_inputs(6, 1);
      be = model_err(6, 4);
      e = be ? 0 : model_diff(0, 4);
      launch(1, 1, 0, lat);
      checks++;
      if (lat !== 10 || b_err !== be || b_diff !== 33'(e) || b_res !== (!be && e > 0) || b_eq !== (!be && e == 0)) begin
        errors++; $display("FAIL random_big[%0d]: lat=%0d err=%b res=%b eq=%b diff=%0d want 10 %b %b %b %0d",
                           it, lat, b_err, b_res, b_eq, $signed(b_diff), be, !be && e > 0, !be && e == 0, e);
      end
    end
    for (int it = 0; it < 12; it++) begin
      randomize_inputs(4, 0);
      if (it == 0) begin bu[0] = au[0]; bv[0] = av[0]; bu[1] = au[1]; bv[1] = av[1]; apply(); end
      e = model_diff(0, 2);
      es = model_diff(1, 2);
      launch(0, 0, 0, lat);
      checks++;
      if (lat !== 6 || m_diff !== 33'(e) || q_diff !== 33'(es) || m_eq !== (e == 0) || q_res !== (es > 0) || m_err !== 1'b0) begin
        errors++; $display("FAIL random_small[%0d]: lat=%0d diff_m=%0d diff_q=%0d eq=%b qres=%b err=%b want 6 %0d %0d %b %b 0",
                           it, lat, $signed(m_diff), $signed(q_diff), m_eq, q_res, m_err, e, es, e == 0, es > 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    longint e1, e2;
    randomize_inputs(6, 0);
    e1 = model_diff(0, 4);
    launch(1, 0, 0, lat1);
    checks++;
    if (lat1 !== 10 || b_diff !== 33'(e1)) begin
      errors++; $display("FAIL b2b_first: lat=%0d diff=%0d want 10 %0d", lat1, $signed(b_diff), e1);
    end
    randomize_inputs(6, 0);
    e2 = model_diff(0, 4);
    @(posedge clk);
    launch(1, 0, 0, lat2);
    checks++;
    if (lat2 !== 10 || b_diff !== 33'(e2)) begin
      errors++; $display("FAIL b2b_second: lat=%0d diff=%0d want 10 %0d", lat2, $signed(b_diff), e2);
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_equal_swap();
    test_max();
    test_err();
    test_ignore_start();
    test_abort();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
